cpu_mbox: RTL and testbench
===========================

# cpu_mbox

Bidirectional byte mailbox between the HuC6280 bus and the MCU, sitting directly downstream of `cpu_io`. It consumes the synchronized `cpu.we_sync`/`cpu.oe_sync` strobes and bus data, and exposes two registers to the CPU: data and status. It holds two independent FIFOs: M-FIFO (CPU→MCU) and C-FIFO (MCU→CPU). The MCU side is a show-ahead push/pop port, with an optional CPU interrupt request.

## Interface
Parameters:
- `DEPTH_LOG2`, 4, log2 of entries per FIFO (16 bytes each).

Ports:
- `clk`  in  1  system clock. One clock domain; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_data`  in  8  CPU write data (`cpu.data`).
- `cpu_we_sync`  in  1  one-cycle strobe per CPU write access.
- `cpu_oe_sync`  in  1  one-cycle strobe per CPU read access.
- `ce_data`  in  1  data register selected.
- `ce_stat`  in  1  status register selected.
- `dato`  out  8  registered CPU read data.
- `mcu_din`  in  8  byte to push into C-FIFO.
- `mcu_wr`  in  1  C-FIFO push strobe.
- `mcu_rd`  in  1  M-FIFO pop strobe.
- `mcu_dout`  out  8  M-FIFO head byte (show-ahead, combinational from storage).
- `m_cnt`  out  `DEPTH_LOG2+1`  M-FIFO occupancy.
- `c_cnt`  out  `DEPTH_LOG2+1`  C-FIFO occupancy.
- `irq`  out  1  registered CPU interrupt request.

## Operation
- Each FIFO uses `DEPTH_LOG2+1`-bit read and write pointers.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
  - Pointers wrap modulo 2^(`DEPTH_LOG2+1`).
- CPU data write (`ce_data & cpu_we_sync`):
  - Pushes `cpu_data` into M-FIFO.
  - If M-FIFO is full, the byte is dropped and `m_ovf` is set.
- CPU data read (`ce_data & cpu_oe_sync`):
  - If C-FIFO is not empty: `dato <=` C-FIFO head, then pop.
  - If C-FIFO is empty: `dato <= 8'hFF` and no pop.
- CPU status read (`ce_stat & cpu_oe_sync`): `dato <= {2'b10, irq_en, m_ovf, c_ovf, m_empty, m_full, c_nempty}`.
- CPU status write (`ce_stat & cpu_we_sync`):
  - bit0=1: flush both FIFOs (all pointers to 0).
  - bit1: load `irq_en`.
  - bit7=1: clear `c_ovf` and `m_ovf`.
- MCU push (`mcu_wr`): writes `mcu_din` into C-FIFO. If C-FIFO is full, the byte is dropped and `c_ovf` is set.
- MCU pop (`mcu_rd`): advances the M-FIFO read pointer. Ignored when M-FIFO is empty.
- `irq <= irq_en & c_nempty`. This is level-type: it clears when the CPU drains C-FIFO.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle are both honoured. The count is unchanged.
  - A push to a full FIFO is accepted if a pop occurs in the same cycle; no overflow is flagged.
  - A pop from an empty FIFO with a simultaneous push: the pop is ignored and the push is accepted.
  - Flush takes priority over any same-cycle push or pop on either side. Those operations are discarded and no overflow flag is set.
  - An overflow set and a bit7 clear in the same cycle: set wins.
- `ce_data` and `ce_stat` are never asserted together. If they are, `ce_data` wins.

## Timing
- Reset values:
  - All pointers are 0.
  - `m_cnt = c_cnt = 0`.
  - `dato = 8'hFF`.
  - `irq_en = c_ovf = m_ovf = 0`.
  - `irq = 0`.
  - `mcu_dout` is undefined while M-FIFO is empty.
- Reset is asynchronous and can assert mid-operation: all state drops to reset values immediately, and FIFO contents are discarded.
- `dato` is valid on the cycle after the `oe_sync` strobe and holds until the next read strobe.
- A push becomes visible on the opposite side one cycle later: `mcu_dout`/`m_cnt` for CPU writes, `c_cnt` and the next `dato` read for MCU pushes.
- `irq` rises 2 cycles after the `mcu_wr` that makes C-FIFO non-empty: 1 cycle for the count, 1 cycle for the register.
- `irq` falls 2 cycles after the draining CPU read.
- Status flags in `dato` reflect state as of the strobe cycle, before any same-cycle update.

## Configuration
- `CPU_MBOX_IRQ_EN` defined:
  - `irq_en` register and `irq` logic are present, as described above.
- `CPU_MBOX_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - `irq_en` is not implemented; status bit5 reads 0.
  - Status write bit1 is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then status read → `dato = 8'h84` (signature `10`, `m_empty=1`, all other flags 0); data read → `8'hFF`; `m_cnt = c_cnt = 0`.
- CPU writes `0x11, 0x22, 0x33` to the data register → `m_cnt = 3`, `mcu_dout = 0x11`; each `mcu_rd` pulse yields `0x22`, then `0x33`, then `m_cnt = 0`.
- Overflow: 17 CPU data writes `0x00..0x10` with no pops → `m_full = 1`, `m_ovf = 1`; pops return `0x00..0x0F`; status write `0x80` clears `m_ovf`.
- Full boundary: M-FIFO full, `mcu_rd` and CPU write of `0xAA` in the same cycle → `m_cnt` stays 16, `m_ovf` stays 0, and `0xAA` is the 16th byte popped.
- With IRQ built in: status write `0x02`, then `mcu_wr` of `0x5A` → `irq` is 1 two cycles later; CPU data read → `dato = 0x5A`, and `irq` is 0 two cycles after. Without the macro, `irq` stays 0 throughout.
- Flush: both FIFOs loaded with 5 bytes; status write `0x01` issued in the same cycle as an `mcu_wr` → `m_cnt = c_cnt = 0`, and a subsequent data read returns `8'hFF`.

Source files
------------

// File: rtl/cpu_mbox_if.sv
// cpu_mbox_if: CPU-side bus bundle for the cpu_mbox mailbox.
// Carries the synchronized bus strobes, the register selects, the write data and the
// registered read data.
//   master : CPU-side driver (drives strobes, selects and data; receives dato)
//   slave  : mailbox side (receives strobes, selects and data; drives dato)
interface cpu_mbox_if;
  logic [7:0] cpu_data;     // CPU write data
  logic       cpu_we_sync;  // one-cycle strobe per CPU write
  logic       cpu_oe_sync;  // one-cycle strobe per CPU read
  logic       ce_data;      // data register selected
  logic       ce_stat;      // status register selected
  logic [7:0] dato;         // registered CPU read data

  modport master (
    output cpu_data, cpu_we_sync, cpu_oe_sync, ce_data, ce_stat,
    input  dato
  );

  modport slave (
    input  cpu_data, cpu_we_sync, cpu_oe_sync, ce_data, ce_stat,
    output dato
  );
endinterface

// File: rtl/cpu_mbox.sv
// cpu_mbox: bidirectional byte mailbox between the HuC6280 bus and the MCU.
// M-FIFO carries CPU->MCU bytes, C-FIFO carries MCU->CPU bytes. The CPU sees a data
// register (push M / pop C) and a status register (flags / flush / irq enable / ovf clear).
// Optional feature macro: CPU_MBOX_IRQ_EN (irq_en register and irq output present).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cpu         : cpu_mbox_if.slave (cpu_data, cpu_we_sync, cpu_oe_sync, ce_data, ce_stat, dato)
//   mcu_din     : byte pushed into C-FIFO on mcu_wr
//   mcu_wr      : C-FIFO push strobe
//   mcu_rd      : M-FIFO pop strobe
//   mcu_dout    : M-FIFO head byte (show-ahead)
//   m_cnt/c_cnt : FIFO occupancies
//   irq         : registered CPU interrupt request
module cpu_mbox #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_mbox_if.slave             cpu,
  input  logic [7:0]            mcu_din,
  input  logic                  mcu_wr,
  input  logic                  mcu_rd,
  output logic [7:0]            mcu_dout,
  output logic [DEPTH_LOG2:0]   m_cnt,
  output logic [DEPTH_LOG2:0]   c_cnt,
  output logic                  irq
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0] ptr_t;

  localparam ptr_t PtrZero = '0;
  localparam ptr_t PtrOne  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam ptr_t PtrMsb  = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0] m_mem [Depth];
  logic [7:0] c_mem [Depth];

  ptr_t m_wp_q, m_wp_d, m_rp_q, m_rp_d;
  ptr_t c_wp_q, c_wp_d, c_rp_q, c_rp_d;
  logic m_ovf_q, m_ovf_d, c_ovf_q, c_ovf_d;
  logic [7:0] dato_q, dato_d;
  logic irq_en;

  // Register decode; ce_data wins if both selects are asserted.
  logic data_sel, stat_sel;
  logic data_wr, data_rd, stat_wr, stat_rd;
  logic flush, ovf_clr;

  assign data_sel = cpu.ce_data;
  assign stat_sel = cpu.ce_stat & ~cpu.ce_data;
  assign data_wr  = data_sel & cpu.cpu_we_sync;
  assign data_rd  = data_sel & cpu.cpu_oe_sync;
  assign stat_wr  = stat_sel & cpu.cpu_we_sync;
  assign stat_rd  = stat_sel & cpu.cpu_oe_sync;
  assign flush    = stat_wr & cpu.cpu_data[0];
  assign ovf_clr  = stat_wr & cpu.cpu_data[7];

  // FIFO flags: full when pointers differ only in the MSB.
  logic m_empty, m_full, c_empty, c_full;

  assign m_empty = (m_wp_q == m_rp_q);
  assign m_full  = ((m_wp_q ^ m_rp_q) == PtrMsb);
  assign c_empty = (c_wp_q == c_rp_q);
  assign c_full  = ((c_wp_q ^ c_rp_q) == PtrMsb);

  // A pop frees the slot for a same-cycle push, so full+pop still accepts the push.
  logic m_pop, m_push, c_pop, c_push;
  logic m_ovf_set, c_ovf_set;

  assign m_pop     = mcu_rd & ~m_empty & ~flush;
  assign m_push    = data_wr & (~m_full | m_pop) & ~flush;
  assign m_ovf_set = data_wr & m_full & ~m_pop & ~flush;

  assign c_pop     = data_rd & ~c_empty & ~flush;
  assign c_push    = mcu_wr & (~c_full | c_pop) & ~flush;
  assign c_ovf_set = mcu_wr & c_full & ~c_pop & ~flush;

  always_comb begin
    m_wp_d = m_wp_q;
    m_rp_d = m_rp_q;
    c_wp_d = c_wp_q;
    c_rp_d = c_rp_q;
    if (flush) begin
      m_wp_d = PtrZero;
      m_rp_d = PtrZero;
      c_wp_d = PtrZero;
      c_rp_d = PtrZero;
    end else begin
      if (m_push) m_wp_d = m_wp_q + PtrOne;
      if (m_pop)  m_rp_d = m_rp_q + PtrOne;
      if (c_push) c_wp_d = c_wp_q + PtrOne;
      if (c_pop)  c_rp_d = c_rp_q + PtrOne;
    end
  end

  // Set wins over a same-cycle clear.
  assign m_ovf_d = m_ovf_set | (m_ovf_q & ~ovf_clr);
  assign c_ovf_d = c_ovf_set | (c_ovf_q & ~ovf_clr);

  // Status reflects pre-update state of the strobe cycle.
  always_comb begin
    dato_d = dato_q;
    if (data_rd) begin
      dato_d = c_empty ? 8'hFF : c_mem[c_rp_q[DEPTH_LOG2-1:0]];
    end else if (stat_rd) begin
      dato_d = {2'b10, irq_en, m_ovf_q, c_ovf_q, m_empty, m_full, ~c_empty};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wp_q  <= PtrZero;
      m_rp_q  <= PtrZero;
      c_wp_q  <= PtrZero;
      c_rp_q  <= PtrZero;
      m_ovf_q <= 1'b0;
      c_ovf_q <= 1'b0;
      dato_q  <= 8'hFF;
    end else begin
      m_wp_q  <= m_wp_d;
      m_rp_q  <= m_rp_d;
      c_wp_q  <= c_wp_d;
      c_rp_q  <= c_rp_d;
      m_ovf_q <= m_ovf_d;
      c_ovf_q <= c_ovf_d;
      dato_q  <= dato_d;
    end
  end

  // Storage needs no reset: contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (m_push) m_mem[m_wp_q[DEPTH_LOG2-1:0]] <= cpu.cpu_data;
    if (c_push) c_mem[c_wp_q[DEPTH_LOG2-1:0]] <= mcu_din;
  end

`ifdef CPU_MBOX_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (stat_wr) irq_en_q <= cpu.cpu_data[1];
      irq_q <= irq_en_q & ~c_empty;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  assign cpu.dato = dato_q;
  assign mcu_dout = m_mem[m_rp_q[DEPTH_LOG2-1:0]];
  assign m_cnt    = m_wp_q - m_rp_q;
  assign c_cnt    = c_wp_q - c_rp_q;

endmodule

// File: tb/tb_cpu_mbox.sv
// Self-checking bench for cpu_mbox: directed scenarios plus randomized traffic, all
// compared against a queue-based behavioural model of the mailbox.
module tb_cpu_mbox;
  localparam int unsigned DL    = 4;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_mbox_if bus ();

  logic [7:0]  mcu_din;
  logic        mcu_wr;
  logic        mcu_rd;
  logic [7:0]  mcu_dout;
  logic [DL:0] m_cnt;
  logic [DL:0] c_cnt;
  logic        irq;

  cpu_mbox #(.DEPTH_LOG2(DL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu      (bus),
    .mcu_din  (mcu_din),
    .mcu_wr   (mcu_wr),
    .mcu_rd   (mcu_rd),
    .mcu_dout (mcu_dout),
    .m_cnt    (m_cnt),
    .c_cnt    (c_cnt),
    .irq      (irq)
  );

  // Behavioural model state.
  logic [7:0] mq[$];
  logic [7:0] cq[$];
  bit         m_ovf, c_ovf, irq_en;
  logic [7:0] exp_dato;
  bit         exp_irq;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cq.delete();
    m_ovf    = 1'b0;
    c_ovf    = 1'b0;
    irq_en   = 1'b0;
    exp_dato = 8'hFF;
    exp_irq  = 1'b0;
  endtask

  task automatic check_all();
    check("m_cnt", m_cnt, mq.size());
    check("c_cnt", c_cnt, cq.size());
    check("dato", bus.dato, exp_dato);
    check("irq", irq, exp_irq);
    if (mq.size() != 0) check("mcu_dout", mcu_dout, mq[0]);
  endtask

  // One clock of stimulus; the model applies the mailbox rules to the same inputs.
  task automatic cycle(input bit we, input bit oe, input bit cd, input bit cs,
                       input logic [7:0] d, input bit mwr, input logic [7:0] mdin,
                       input bit mrd);
    bit sel_d, sel_s, c_nempty, m_set, c_set, nxt_irq;
    logic [7:0] stat;
    @(negedge clk);
    bus.cpu_we_sync = we;
    bus.cpu_oe_sync = oe;
    bus.ce_data     = cd;
    bus.ce_stat     = cs;
    bus.cpu_data    = d;
    mcu_wr          = mwr;
    mcu_din         = mdin;
    mcu_rd          = mrd;

    sel_d    = cd;
    sel_s    = cs & ~cd;
    c_nempty = (cq.size() != 0);
    m_set    = 1'b0;
    c_set    = 1'b0;
`ifdef CPU_MBOX_IRQ_EN
    nxt_irq = irq_en & c_nempty;
`else
    nxt_irq = 1'b0;
`endif
    stat = {2'b10, irq_en, m_ovf, c_ovf, mq.size() == 0, mq.size() == Depth, c_nempty};
    if (sel_d && oe) exp_dato = c_nempty ? cq[0] : 8'hFF;
    else if (sel_s && oe) exp_dato = stat;

    if (sel_s && we && d[0]) begin
      mq.delete();
      cq.delete();
    end else begin
      if (mrd && mq.size() != 0) void'(mq.pop_front());
      if (sel_d && we) begin
        if (mq.size() < Depth) mq.push_back(d);
        else m_set = 1'b1;
      end
      if (sel_d && oe && cq.size() != 0) void'(cq.pop_front());
      if (mwr) begin
        if (cq.size() < Depth) cq.push_back(mdin);
        else c_set = 1'b1;
      end
    end
    if (sel_s && we && d[7]) begin
      m_ovf = 1'b0;
      c_ovf = 1'b0;
    end
    if (m_set) m_ovf = 1'b1;
    if (c_set) c_ovf = 1'b1;
`ifdef CPU_MBOX_IRQ_EN
    if (sel_s && we) irq_en = d[1];
`endif
    exp_irq = nxt_irq;

    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();           cycle(0, 0, 0, 0, 8'h00, 0, 8'h00, 0); endtask
  task automatic cpu_wr(input logic [7:0] d);  cycle(1, 0, 1, 0, d, 0, 8'h00, 0); endtask
  task automatic cpu_rd();         cycle(0, 1, 1, 0, 8'h00, 0, 8'h00, 0); endtask
  task automatic stat_rd();        cycle(0, 1, 0, 1, 8'h00, 0, 8'h00, 0); endtask
  task automatic stat_wr(input logic [7:0] d); cycle(1, 0, 0, 1, d, 0, 8'h00, 0); endtask
  task automatic mpush(input logic [7:0] d);   cycle(0, 0, 0, 0, 8'h00, 1, d, 0); endtask
  task automatic mpop();           cycle(0, 0, 0, 0, 8'h00, 0, 8'h00, 1); endtask

  task automatic set_idle_inputs();
    bus.cpu_we_sync = 1'b0;
    bus.cpu_oe_sync = 1'b0;
    bus.ce_data     = 1'b0;
    bus.ce_stat     = 1'b0;
    bus.cpu_data    = 8'h00;
    mcu_wr          = 1'b0;
    mcu_rd          = 1'b0;
    mcu_din         = 8'h00;
  endtask

  // Asynchronous reset asserted mid-cycle; state must drop without waiting for an edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    set_idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_m_cnt", m_cnt, 0);
    check("rst_c_cnt", c_cnt, 0);
    check("rst_dato", bus.dato, 8'hFF);
    check("rst_irq", irq, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_traffic(input int n, input bit fill_heavy);
    int r;
    bit we, oe, cd, cs, mwr, mrd;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 9);
      cd = (r <= 4) || (r == 7);
      cs = (r == 5) || (r == 6) || (r == 7);
      r  = $urandom_range(0, 2);
      we = (r == 0);
      oe = (r == 1);
      d  = 8'($urandom);
      // Keep flushes rare so the FIFOs actually reach full.
      if (cs && !cd && we && $urandom_range(0, 7) != 0) d[0] = 1'b0;
      if (fill_heavy) begin
        mwr = ($urandom_range(0, 3) != 0);
        mrd = ($urandom_range(0, 5) == 0);
        if (cd && oe && $urandom_range(0, 2) != 0) oe = 1'b0;
      end else begin
        mwr = ($urandom_range(0, 4) == 0);
        mrd = ($urandom_range(0, 1) == 0);
      end
      cycle(we, oe, cd, cs, d, mwr, 8'($urandom), mrd);
    end
  endtask

  initial begin
    set_idle_inputs();
    model_reset();
    #12;
    rst_n = 1'b1;
    idle();

    // Reset state through the register interface.
    stat_rd();
    check("stat_after_reset", bus.dato, 8'h84);
    cpu_rd();
    check("data_rd_empty", bus.dato, 8'hFF);

    // Basic CPU->MCU path with show-ahead head.
    cpu_wr(8'h11);
    cpu_wr(8'h22);
    cpu_wr(8'h33);
    check("m_cnt_3", m_cnt, 3);
    check("head_11", mcu_dout, 8'h11);
    mpop();
    check("head_22", mcu_dout, 8'h22);
    mpop();
    check("head_33", mcu_dout, 8'h33);
    mpop();
    check("m_cnt_0", m_cnt, 0);

    // Overflow on the 17th write.
    for (int i = 0; i < 17; i++) cpu_wr(8'(i));
    stat_rd();
    check("stat_m_ovf_full", bus.dato, 8'h92);
    for (int i = 0; i < 16; i++) begin
      check("ovf_pop_order", mcu_dout, 8'(i));
      mpop();
    end
    stat_wr(8'h80);
    stat_rd();
    check("stat_ovf_cleared", bus.dato, 8'h84);

    // Full boundary: push with a same-cycle pop is accepted without overflow.
    for (int i = 0; i < 16; i++) cpu_wr(8'(8'h40 + i));
    cycle(1, 0, 1, 0, 8'hAA, 0, 8'h00, 1);
    check("full_pop_push_cnt", m_cnt, 16);
    stat_rd();
    check("full_pop_push_stat", bus.dato, 8'h82);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("aa_is_16th", mcu_dout, 8'hAA);
      mpop();
    end

    // Interrupt request: two cycles to rise, two to fall.
    stat_wr(8'h02);
    mpush(8'h5A);
    idle();
`ifdef CPU_MBOX_IRQ_EN
    check("irq_rise", irq, 1);
`else
    check("irq_tied_low", irq, 0);
`endif
    cpu_rd();
    check("irq_data_5a", bus.dato, 8'h5A);
    idle();
    check("irq_fall", irq, 0);
    stat_wr(8'h00);

    // Flush wins over a same-cycle MCU push.
    for (int i = 0; i < 5; i++) begin
      cpu_wr(8'(8'hC0 + i));
      mpush(8'(8'hD0 + i));
    end
    cycle(1, 0, 0, 1, 8'h01, 1, 8'hEE, 0);
    check("flush_m_cnt", m_cnt, 0);
    check("flush_c_cnt", c_cnt, 0);
    cpu_rd();
    check("flush_data_rd", bus.dato, 8'hFF);

    // Randomized traffic with alternating fill/drain bias and a mid-run reset.
    for (int p = 0; p < 6; p++) random_traffic(400, (p % 2) == 0);
    do_reset();
    idle();
    for (int p = 0; p < 4; p++) random_traffic(300, (p % 2) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
